strobe_gen_multi: RTL and testbench
===================================

// Module: strobe_gen_multi
// PURPOSE
//  NCH-channel programmable strobe divider: the parametrised successor of the single 8-bit strobe generator.
//  Each channel divides the shared qualifying strobe_in by (rate+1) and has its own start phase.
//  Each channel runs in continuous or counted-burst mode, with a global resync input.
//  Sits between the master sample-rate strobe and the per-channel decimator/interp enables.
// PARAMETERS
//  NCH    4   number of independent channels
//  WIDTH  8   divider counter width (rate, phase)
//  CNTW   16  burst length counter width
// PORTS
//  clock       in   1           system clock
//  reset       in   1           synchronous, active-high
//  strobe_in   in   1           shared qualifying strobe; counters advance only when high
//  sync        in   1           resync: all RUN channels reload counter with phase
//  enable      in   NCH         per-channel enable; low forces channel to IDLE
//  rate        in   NCH*WIDTH   divide ratio minus 1, ch i at [i*WIDTH +: WIDTH]
//  phase       in   NCH*WIDTH   counter load value at start/resync (strobe_in cycles to first strobe)
//  burst_mode  in   NCH         1 = stop after burst_len strobes; 0 = continuous
//  burst_len   in   NCH*CNTW    strobes per burst; 0 = unlimited
//  strobe      out  NCH         one-cycle divided strobe (combinational from state)
//  busy        out  NCH         registered; high while channel in RUN
//  done        out  NCH         registered one-cycle pulse after final burst strobe
// BEHAVIOUR
//  Reset: all channels IDLE; counter=0, burst_cnt=0; strobe, busy and done = 0. Reset has priority over everything.
//  Per-channel FSM, IDLE/RUN/HALT:
//   IDLE: enable=1 -> RUN next clock. Load counter<=phase.
//    Latch burst_mode and burst_len into the channel. Later changes to them are ignored until re-arm.
//   RUN: strobe = counter==0 && strobe_in && !sync.
//    On strobe_in && !sync: counter==0 -> counter<=rate (sampled only here), else counter-1.
//    Mid-period rate changes therefore take effect after the current period.
//    rate=0 -> strobe on every strobe_in cycle; rate=2^WIDTH-1 -> divide by 2^WIDTH.
//   Burst: latched burst_mode=1 and burst_len!=0 -> burst_cnt loaded with burst_len at IDLE->RUN.
//    burst_cnt decrements on each strobe. A strobe with burst_cnt==1 -> HALT next clock; done=1 that cycle.
//   HALT: strobe=0, busy=0, counter held. Leaves only via enable=0 -> IDLE.
//    Re-arm needs enable low for >=1 clock.
//   enable=0 in any state -> IDLE next clock, counter<=0. Any in-flight burst is aborted without a done pulse.
//  sync=1: every RUN channel gets counter<=phase. No strobe that cycle, even if counter==0.
//   burst_cnt is unchanged. IDLE/HALT channels ignore sync.
//  sync and strobe_in together: sync wins; strobe_in is consumed with no count.
//  Latency: enable rise at edge k -> RUN at k+1; first strobe at the (phase+1)-th strobe_in cycle after that.
//  phase=0 reproduces the legacy behaviour: first strobe_in strobes immediately.
//  Channels are fully independent apart from the shared strobe_in and sync.
//  Counter arithmetic is unsigned WIDTH-bit with no wrap beyond reload, because counter==0 always reloads.
// TESTING
//  1 ch0 rate=3 phase=0, strobe_in=1 constant -> strobe ch0 at cycles 1,5,9,... after RUN; period 4.
//  2 ch1 rate=2 phase=1, strobe_in high every 2nd clock -> first strobe on 2nd strobe_in, then every 3rd strobe_in.
//  3 ch2 burst_mode=1 burst_len=3 rate=0 -> exactly 3 strobes, done pulse 1 clock, busy 0; enable 0->1 re-arms.
//  4 rate change 3->1 mid-period -> current period stays 4, following periods 2.
//  5 sync asserted with counter==0 and strobe_in=1 -> no strobe; all RUN channels restart from phase; burst_cnt unchanged.
//  6 reset or enable=0 mid-burst -> outputs 0 next clock, no done; rerun with rate=255 -> divide-by-256 with no overflow.

Source files
------------

// File: rtl/strobe_gen_multi.sv
// Multi-channel programmable strobe divider with per-channel start phase, counted-burst mode and global resync.
// One channel instance per divider output; channels share only strobe_in and sync.

module strobe_gen_chan #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             strobe_in,
   input  logic             sync,
   input  logic             enable,
   input  logic [WIDTH-1:0] rate,
   input  logic [WIDTH-1:0] phase,
   input  logic             burst_mode,
   input  logic [CNTW-1:0]  burst_len,
   output logic             strobe,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] counter_q;
   logic [CNTW-1:0]  burst_cnt_q;
   logic             burst_en_q;
   logic             busy_q;
   logic             done_q;
   logic             advance;
   logic             at_zero;

   // sync consumes a coincident strobe_in without counting it
   assign advance = strobe_in && !sync;
   assign at_zero = (counter_q == '0);

   assign strobe    = (state_q == ST_RUN) && at_zero && advance;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         counter_q   <= '0;
         burst_cnt_q <= '0;
         burst_en_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!enable) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  // burst settings are latched here and ignored until the next re-arm
                  state_q     <= ST_RUN;
                  busy_q      <= 1'b1;
                  counter_q   <= phase;
                  burst_en_q  <= burst_mode && (burst_len != '0);
                  burst_cnt_q <= burst_mode ? burst_len : '0;
               end
               ST_RUN: begin
                  if (sync) begin
                     counter_q <= phase;
                  end else if (strobe_in) begin
                     if (at_zero) begin
                        counter_q <= rate;
                        if (burst_en_q) begin
                           burst_cnt_q <= burst_cnt_q - CNTW'(1);
                           if (burst_cnt_q == CNTW'(1)) begin
                              state_q <= ST_HALT;
                              busy_q  <= 1'b0;
                              done_q  <= 1'b1;
                           end
                        end
                     end else begin
                        counter_q <= counter_q - WIDTH'(1);
                     end
                  end
               end
               ST_HALT: begin
                  busy_q <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

module strobe_gen_multi #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  strobe_in,
   input  logic                  sync,
   input  logic [NCH-1:0]        enable,
   input  logic [NCH*WIDTH-1:0]  rate,
   input  logic [NCH*WIDTH-1:0]  phase,
   input  logic [NCH-1:0]        burst_mode,
   input  logic [NCH*CNTW-1:0]   burst_len,
   output logic [NCH-1:0]        strobe,
   output logic [NCH-1:0]        busy,
   output logic [NCH-1:0]        done,
   output logic [2*NCH-1:0]      state_dbg
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      strobe_gen_chan #(
         .WIDTH (WIDTH),
         .CNTW  (CNTW)
      ) u_chan (
         .clock      (clock),
         .reset      (reset),
         .strobe_in  (strobe_in),
         .sync       (sync),
         .enable     (enable[i]),
         .rate       (rate[i*WIDTH +: WIDTH]),
         .phase      (phase[i*WIDTH +: WIDTH]),
         .burst_mode (burst_mode[i]),
         .burst_len  (burst_len[i*CNTW +: CNTW]),
         .strobe     (strobe[i]),
         .busy       (busy[i]),
         .done       (done[i]),
         .state_dbg  (state_dbg[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Directed bench for strobe_gen_multi: hand-computed strobe/busy/done bit patterns per channel.
// Bit k of a pattern is the output value in the k-th cycle sampled by run().

module tb_strobe_gen_multi;

   localparam int NCH   = 4;
   localparam int WIDTH = 8;
   localparam int CNTW  = 16;

   logic                 clock      = 1'b0;
   logic                 reset      = 1'b1;
   logic                 strobe_in  = 1'b0;
   logic                 sync       = 1'b0;
   logic [NCH-1:0]       enable     = '0;
   logic [NCH*WIDTH-1:0] rate       = '0;
   logic [NCH*WIDTH-1:0] phase      = '0;
   logic [NCH-1:0]       burst_mode = '0;
   logic [NCH*CNTW-1:0]  burst_len  = '0;
   logic [NCH-1:0]       strobe;
   logic [NCH-1:0]       busy;
   logic [NCH-1:0]       done;
   logic [2*NCH-1:0]     state_dbg;

   int checks = 0;
   int errors = 0;

   logic [31:0] st_pat [NCH];
   logic [31:0] bz_pat [NCH];
   logic [31:0] dn_pat [NCH];

   strobe_gen_multi #(
      .NCH   (NCH),
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .strobe_in  (strobe_in),
      .sync       (sync),
      .enable     (enable),
      .rate       (rate),
      .phase      (phase),
      .burst_mode (burst_mode),
      .burst_len  (burst_len),
      .strobe     (strobe),
      .busy       (busy),
      .done       (done),
      .state_dbg  (state_dbg)
   );

   // clock / watchdog
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive strobe_in high on every si_per-th cycle (starting with the first) and record outputs.
   task automatic run(input int n, input int si_per);
      for (int c = 0; c < NCH; c++) begin
         st_pat[c] = '0;
         bz_pat[c] = '0;
         dn_pat[c] = '0;
      end
      for (int k = 0; k < n; k++) begin
         strobe_in = ((k % si_per) == 0);
         #1;
         for (int c = 0; c < NCH; c++) begin
            st_pat[c][k] = strobe[c];
            bz_pat[c][k] = busy[c];
            dn_pat[c][k] = done[c];
         end
         tick();
      end
   endtask

   int n_st;
   int pos [4];

   initial begin
      // reset: held with every channel enabled and strobe_in high
      reset     = 1'b1;
      enable    = '1;
      strobe_in = 1'b1;
      repeat (3) tick();
      check("rst_strobe", strobe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", state_dbg, 0);
      enable    = '0;
      strobe_in = 1'b0;
      reset     = 1'b0;
      tick();

      // T1: ch0 rate=3 phase=0, strobe_in constant -> period 4 from first RUN cycle
      rate[0*WIDTH +: WIDTH] = 8'd3;
      enable[0] = 1'b1;
      tick();
      run(16, 1);
      check("t1_strobe", st_pat[0][15:0], 16'h1111);
      check("t1_busy", bz_pat[0][15:0], 16'hFFFF);
      enable[0] = 1'b0;
      strobe_in = 1'b0;
      tick();
      check("t1_idle_busy", busy[0], 0);

      // T2: ch1 rate=2 phase=1, strobe_in every 2nd clock
      rate[1*WIDTH +: WIDTH]  = 8'd2;
      phase[1*WIDTH +: WIDTH] = 8'd1;
      enable[1] = 1'b1;
      tick();
      run(24, 2);
      check("t2_strobe", st_pat[1][23:0], 24'h104104);
      enable[1] = 1'b0;
      strobe_in = 1'b0;
      tick();

      // T3: ch2 burst of 3 at rate 0; inputs changed after arming must be ignored
      rate[2*WIDTH +: WIDTH]   = 8'd0;
      burst_mode[2]            = 1'b1;
      burst_len[2*CNTW +: CNTW] = 16'd3;
      enable[2] = 1'b1;
      tick();
      burst_mode[2]             = 1'b0;
      burst_len[2*CNTW +: CNTW] = 16'd10;
      run(8, 1);
      check("t3_strobe", st_pat[2][7:0], 8'h07);
      check("t3_busy", bz_pat[2][7:0], 8'h07);
      check("t3_done", dn_pat[2][7:0], 8'h08);
      check("t3_halt_state", state_dbg[5:4], 2'd2);
      burst_mode[2]             = 1'b1;
      burst_len[2*CNTW +: CNTW] = 16'd3;
      enable[2] = 1'b0;
      tick();
      check("t3_idle_state", state_dbg[5:4], 2'd0);
      enable[2] = 1'b1;
      tick();
      run(8, 1);
      check("t3_rearm_strobe", st_pat[2][7:0], 8'h07);
      check("t3_rearm_done", dn_pat[2][7:0], 8'h08);
      enable[2] = 1'b0;
      strobe_in = 1'b0;
      tick();

      // T4: ch3 rate 3 -> 1 mid-period: current period stays 4, then period 2
      rate[3*WIDTH +: WIDTH] = 8'd3;
      enable[3] = 1'b1;
      tick();
      run(2, 1);
      check("t4_first", st_pat[3][1:0], 2'b01);
      rate[3*WIDTH +: WIDTH] = 8'd1;
      run(10, 1);
      check("t4_after", st_pat[3][9:0], 10'h154);
      enable[3] = 1'b0;
      strobe_in = 1'b0;
      tick();

      // T5: sync with ch0 at counter 0; ch1 in a burst of 4 keeps its remaining count
      rate[0*WIDTH +: WIDTH]    = 8'd3;
      phase[0*WIDTH +: WIDTH]   = 8'd2;
      burst_mode[0]             = 1'b0;
      rate[1*WIDTH +: WIDTH]    = 8'd1;
      phase[1*WIDTH +: WIDTH]   = 8'd0;
      burst_mode[1]             = 1'b1;
      burst_len[1*CNTW +: CNTW] = 16'd4;
      enable[1:0] = 2'b11;
      tick();
      run(2, 1);
      check("t5_pre_ch0", st_pat[0][1:0], 2'b00);
      check("t5_pre_ch1", st_pat[1][1:0], 2'b01);
      sync      = 1'b1;
      strobe_in = 1'b1;
      #1;
      check("t5_sync_strobe", strobe, 0);
      tick();
      sync = 1'b0;
      run(7, 1);
      check("t5_post_ch0", st_pat[0][6:0], 7'h44);
      check("t5_post_ch1", st_pat[1][6:0], 7'h15);
      check("t5_post_busy1", bz_pat[1][6:0], 7'h1F);
      check("t5_post_done1", dn_pat[1][6:0], 7'h20);
      enable[1:0] = 2'b00;
      strobe_in   = 1'b0;
      tick();

      // T6a: enable dropped on what would have been the final burst strobe
      burst_mode[2]             = 1'b1;
      burst_len[2*CNTW +: CNTW] = 16'd3;
      enable[2] = 1'b1;
      tick();
      run(2, 1);
      check("t6_pre_strobe", st_pat[2][1:0], 2'b11);
      enable[2] = 1'b0;
      tick();
      run(6, 1);
      check("t6_abort_strobe", st_pat[2][5:0], 0);
      check("t6_abort_busy", bz_pat[2][5:0], 0);
      check("t6_abort_done", dn_pat[2][5:0], 0);

      // T6b: reset on what would have been the final burst strobe
      enable[2] = 1'b1;
      tick();
      run(2, 1);
      reset = 1'b1;
      tick();
      check("t6_rst_outputs", {strobe[2], busy[2], done[2]}, 3'b000);
      run(3, 1);
      check("t6_rst_done", dn_pat[2][2:0], 0);
      reset     = 1'b0;
      enable    = '0;
      strobe_in = 1'b0;
      tick();

      // T6c: ch3 rate=255 continuous -> divide by 256
      rate[3*WIDTH +: WIDTH]  = 8'd255;
      phase[3*WIDTH +: WIDTH] = 8'd0;
      burst_mode[3] = 1'b0;
      enable[3] = 1'b1;
      tick();
      n_st = 0;
      for (int k = 0; k < 4; k++) pos[k] = -1;
      for (int k = 0; k < 520; k++) begin
         strobe_in = 1'b1;
         #1;
         if (strobe[3]) begin
            if (n_st < 4) pos[n_st] = k;
            n_st++;
         end
         tick();
      end
      check("t6_div256_count", n_st, 3);
      check("t6_div256_first", pos[0], 0);
      check("t6_div256_second", pos[1], 256);
      check("t6_div256_third", pos[2], 512);
      enable    = '0;
      strobe_in = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
